// File: rtl/axi_stream_skid_buffer.sv
// axi_stream_skid_buffer
// Two-entry AXI4-Stream register slice. Every m_* output and s_tready come
// straight from flops, so no combinational path crosses the block, including
// the ready path. The slice also keeps running byte and packet counts of the
// beats it delivers downstream.
//
// Ports:
//   clk, resetn          clock; asynchronous active-low reset
//   s_t*                 upstream AXI-Stream slave side (s_tready registered)
//   m_t*                 downstream AXI-Stream master side (all registered)
//   byte_count           TKEEP-qualified bytes delivered, wraps
//   packet_count         TLAST beats delivered, wraps
module axi_stream_skid_buffer #(
   parameter int byte_width  = 4,
   parameter int id_width    = 1,
   parameter int dest_width  = 1,
   parameter int user_width  = 1,
   parameter int count_width = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic [8*byte_width-1:0]  s_tdata,
   input  logic [byte_width-1:0]    s_tstrb,
   input  logic [byte_width-1:0]    s_tkeep,
   input  logic                     s_tlast,
   input  logic [id_width-1:0]      s_tid,
   input  logic [dest_width-1:0]    s_tdest,
   input  logic [user_width-1:0]    s_tuser,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [8*byte_width-1:0]  m_tdata,
   output logic [byte_width-1:0]    m_tstrb,
   output logic [byte_width-1:0]    m_tkeep,
   output logic                     m_tlast,
   output logic [id_width-1:0]      m_tid,
   output logic [dest_width-1:0]    m_tdest,
   output logic [user_width-1:0]    m_tuser,
   output logic [count_width-1:0]   byte_count,
   output logic [count_width-1:0]   packet_count
);

   localparam int PW = 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t                 state_q, state_d;
   logic                   m_tvalid_q, s_tready_q;
   logic [PW-1:0]          out_q, skid_q, s_pld;
   logic [count_width-1:0] byte_cnt_q, pkt_cnt_q, keep_pop;
   logic                   in_xfer, out_xfer;
   logic                   load_out, load_skid, skid_to_out;

   assign s_pld = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
   assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

   assign m_tvalid     = m_tvalid_q;
   assign s_tready     = s_tready_q;
   assign byte_count   = byte_cnt_q;
   assign packet_count = pkt_cnt_q;

   assign in_xfer  = s_tvalid & s_tready_q;
   assign out_xfer = m_tvalid_q & m_tready;

   // FULL never sees in_xfer (s_tready is low there), EMPTY never sees
   // out_xfer (m_tvalid is low there), so those cases need no handling.
   always_comb begin
      state_d     = state_q;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state_q)
         EMPTY: if (in_xfer) begin
            state_d  = ONE;
            load_out = 1'b1;
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_out = 1'b1;
            end else if (in_xfer) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: if (out_xfer) begin
            state_d     = ONE;
            skid_to_out = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs are registered from the next state. s_tready stays low
   // through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= EMPTY;
         m_tvalid_q <= 1'b0;
         s_tready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_tvalid_q <= (state_d != EMPTY);
         s_tready_q <= (state_d != FULL);
      end
   end

   // Payload storage needs no reset; it is only observed while valid.
   always_ff @(posedge clk) begin
      if (load_out)         out_q <= s_pld;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= s_pld;
   end

   always_comb begin
      keep_pop = '0;
      for (int i = 0; i < byte_width; i++)
         keep_pop = keep_pop + count_width'(m_tkeep[i]);
   end

   // Counts track delivered beats only; position bytes (TSTRB=0) still count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         byte_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else if (out_xfer) begin
         byte_cnt_q <= byte_cnt_q + keep_pop;
         if (m_tlast) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Bench for axi_stream_skid_buffer. Two instances share stimulus: a 32-bit
// counter build and a 4-bit counter build that exercises wrap-around.
module tb_axi_stream_skid_buffer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic [3:0]  k;
      logic        l;
      logic [1:0]  i;
      logic [2:0]  de;
      logic [3:0]  u;
   } beat_t;

   logic  clk = 1'b0;
   logic  resetn = 1'b0;
   logic  s_tvalid = 1'b0;
   logic  m_tready = 1'b0;
   beat_t sb = '0;

   always #5 clk = ~clk;

   logic        s_tready, m_tvalid, m_tlast;
   logic [31:0] m_tdata, byte_count, packet_count;
   logic [3:0]  m_tstrb, m_tkeep, m_tuser;
   logic [1:0]  m_tid;
   logic [2:0]  m_tdest;

   logic        s_tready_s, m_tvalid_s, m_tlast_s;
   logic [31:0] m_tdata_s;
   logic [3:0]  m_tstrb_s, m_tkeep_s, m_tuser_s, byte_count_s, packet_count_s;
   logic [1:0]  m_tid_s;
   logic [2:0]  m_tdest_s;

   beat_t mb, mb_s;
   assign mb   = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
   assign mb_s = {m_tdata_s, m_tstrb_s, m_tkeep_s, m_tlast_s, m_tid_s, m_tdest_s, m_tuser_s};

   axi_stream_skid_buffer #(.byte_width(4), .id_width(2), .dest_width(3),
                            .user_width(4), .count_width(32)) u_dut (
      .clk(clk), .resetn(resetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(sb.d), .s_tstrb(sb.s),
      .s_tkeep(sb.k), .s_tlast(sb.l), .s_tid(sb.i), .s_tdest(sb.de), .s_tuser(sb.u),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
      .m_tuser(m_tuser), .byte_count(byte_count), .packet_count(packet_count));

   axi_stream_skid_buffer #(.byte_width(4), .id_width(2), .dest_width(3),
                            .user_width(4), .count_width(4)) u_small (
      .clk(clk), .resetn(resetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready_s), .s_tdata(sb.d), .s_tstrb(sb.s),
      .s_tkeep(sb.k), .s_tlast(sb.l), .s_tid(sb.i), .s_tdest(sb.de), .s_tuser(sb.u),
      .m_tvalid(m_tvalid_s), .m_tready(m_tready), .m_tdata(m_tdata_s), .m_tstrb(m_tstrb_s),
      .m_tkeep(m_tkeep_s), .m_tlast(m_tlast_s), .m_tid(m_tid_s), .m_tdest(m_tdest_s),
      .m_tuser(m_tuser_s), .byte_count(byte_count_s), .packet_count(packet_count_s));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the slice is a two-deep FIFO. Head is what m_* shows; ready is
   // "not full", except that ready is held low until one edge after reset.
   beat_t   q[$];
   bit      rdy_en = 1'b0;
   longint  exp_bytes = 0;
   longint  exp_pkts = 0;
   bit      in_x, out_x;
   beat_t   pb;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q.delete();
         rdy_en    = 1'b0;
         exp_bytes = 0;
         exp_pkts  = 0;
      end else begin
         in_x  = s_tvalid && rdy_en && (q.size() < 2);
         out_x = (q.size() > 0) && m_tready;
         if (out_x) begin
            pb = q.pop_front();
            exp_bytes += $countones(pb.k);
            if (pb.l) exp_pkts++;
         end
         if (in_x) q.push_back(sb);
         rdy_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("s_tready", 64'(s_tready), 64'(rdy_en && (q.size() < 2)));
      chk("m_tvalid", 64'(m_tvalid), 64'(q.size() > 0));
      if (q.size() > 0) chk("m_payload", 64'(mb), 64'(q[0]));
      chk("byte_count", 64'(byte_count), 64'(exp_bytes[31:0]));
      chk("packet_count", 64'(packet_count), 64'(exp_pkts[31:0]));
      chk("s_tready_small", 64'(s_tready_s), 64'(rdy_en && (q.size() < 2)));
      chk("m_tvalid_small", 64'(m_tvalid_s), 64'(q.size() > 0));
      if (q.size() > 0) chk("m_payload_small", 64'(mb_s), 64'(q[0]));
      chk("byte_count_small", 64'(byte_count_s), 64'(exp_bytes[3:0]));
      chk("packet_count_small", 64'(packet_count_s), 64'(exp_pkts[3:0]));
   end

   function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                                input logic [3:0] s, input logic l);
      beat_t b;
      b.d  = d;
      b.k  = k;
      b.s  = s;
      b.l  = l;
      b.i  = d[1:0];
      b.de = d[4:2];
      b.u  = d[8:5];
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      step();
   endtask

   // Presents one beat and holds it until accepted (bounded).
   task automatic send(input beat_t b);
      logic rdy;
      int   n;
      s_tvalid = 1'b1;
      sb = b;
      n = 0;
      forever begin
         rdy = s_tready;
         step();
         n++;
         if (rdy) break;
         if (n > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", b.d);
            break;
         end
      end
   endtask

   initial begin
      int   idx, cyc;
      logic rdy;

      // Reset with valid asserted upstream
      resetn = 1'b0; s_tvalid = 1'b1; m_tready = 1'b0;
      sb = mk(32'hA5, 4'hF, 4'hF, 1'b0);
      repeat (3) step();
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_byte_count", 64'(byte_count), 64'd0);
      chk("rst_packet_count", 64'(packet_count), 64'd0);
      resetn = 1'b1;
      #1 chk("release_s_tready_low", 64'(s_tready), 64'd0);
      step();
      chk("release_s_tready_high", 64'(s_tready), 64'd1);
      chk("release_m_tvalid", 64'(m_tvalid), 64'd0);
      step();
      chk("first_beat_valid", 64'(m_tvalid), 64'd1);
      chk("first_beat_data", 64'(m_tdata), 64'hA5);
      s_tvalid = 1'b0; m_tready = 1'b1;
      step();

      // Streaming 8 beats at full rate
      do_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(mk(32'(i), 4'hF, 4'hF, i == 7));
         chk("stream_data", 64'(m_tdata), 64'(i));
      end
      s_tvalid = 1'b0;
      step();
      chk("stream_bytes", 64'(byte_count), 64'd32);
      chk("stream_pkts", 64'(packet_count), 64'd1);
      chk("stream_bytes_wrap", 64'(byte_count_s), 64'd0);
      chk("stream_pkts_small", 64'(packet_count_s), 64'd1);

      // Backpressure: 5 stalled cycles, then release
      do_reset();
      m_tready = 1'b0; idx = 0; s_tvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sb = mk(32'h10 + 32'(idx), 4'hF, 4'hF, idx == 5);
         rdy = s_tready;
         step();
         if (rdy) idx++;
      end
      chk("bp_accepted", 64'(idx), 64'd2);
      chk("bp_s_tready", 64'(s_tready), 64'd0);
      chk("bp_head", 64'(m_tdata), 64'h10);
      m_tready = 1'b1; cyc = 0;
      while (idx < 6 && cyc < 50) begin
         sb = mk(32'h10 + 32'(idx), 4'hF, 4'hF, idx == 5);
         rdy = s_tready;
         step();
         if (rdy) idx++;
         cyc++;
      end
      s_tvalid = 1'b0;
      repeat (3) step();
      chk("bp_bytes", 64'(byte_count), 64'd24);
      chk("bp_pkts", 64'(packet_count), 64'd1);

      // Byte counting with position and null bytes
      do_reset();
      m_tready = 1'b1;
      send(mk(32'h1, 4'b0011, 4'b0001, 1'b0));
      send(mk(32'h2, 4'b0000, 4'b0000, 1'b0));
      send(mk(32'h3, 4'b1111, 4'b1111, 1'b1));
      s_tvalid = 1'b0;
      step();
      chk("cnt_bytes", 64'(byte_count), 64'd6);
      chk("cnt_pkts", 64'(packet_count), 64'd1);
      chk("cnt_bytes_small", 64'(byte_count_s), 64'd6);

      // Random valid/ready traffic
      do_reset();
      idx = 0; cyc = 0; s_tvalid = 1'b0;
      while (idx < 1000 && cyc < 20000) begin
         if (!s_tvalid) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            sb.d = $urandom; sb.s = 4'($urandom); sb.k = 4'($urandom);
            sb.l = 1'($urandom); sb.i = 2'($urandom); sb.de = 3'($urandom);
            sb.u = 4'($urandom);
         end
         m_tready = 1'($urandom_range(0, 1));
         rdy = s_tready;
         step();
         if (s_tvalid && rdy) begin
            idx++;
            s_tvalid = 1'b0;
         end
         cyc++;
      end
      if (idx < 1000) begin
         n_checks++;
         n_fail++;
         $display("FAIL random_timeout: only %0d of 1000 beats accepted", idx);
      end
      s_tvalid = 1'b0; m_tready = 1'b1;
      repeat (4) step();

      // Reset asserted between edges while FULL
      do_reset();
      m_tready = 1'b0;
      send(mk(32'h111, 4'hF, 4'hF, 1'b0));
      send(mk(32'h222, 4'hF, 4'hF, 1'b0));
      s_tvalid = 1'b0;
      chk("mid_full_s_tready", 64'(s_tready), 64'd0);
      #3 resetn = 1'b0;
      #1;
      chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
      step(); step();
      resetn = 1'b1;
      step();
      m_tready = 1'b1;
      send(mk(32'hEE, 4'hF, 4'hF, 1'b1));
      chk("mid_new_data", 64'(m_tdata), 64'hEE);
      s_tvalid = 1'b0;
      step();
      chk("mid_bytes", 64'(byte_count), 64'd4);
      chk("mid_pkts", 64'(packet_count), 64'd1);
      chk("mid_m_tvalid_idle", 64'(m_tvalid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_stream_skid_buffer.md
Name: axi_stream_skid_buffer

Overview:
Full-throughput two-entry AXI4-Stream register slice that breaks all combinational paths between an upstream master and a downstream slave, including the TREADY path. It sits directly in front of any port checked by the AXI-Stream slave property set and must drive that port legally under every stimulus. It also reports running byte and packet counts of the traffic it delivers.

Parameters:
- byte_width, 4, TDATA width in bytes (>=1); TSTRB/TKEEP are byte_width bits
- id_width, 1, TID width (>=1; tie off when unused)
- dest_width, 1, TDEST width (>=1; tie off when unused)
- user_width, 1, TUSER width (>=1; tie off when unused)
- count_width, 32, width of the byte_count and packet_count outputs

Ports:
- clk  in  1  single clock
- resetn  in  1  reset, asynchronous and active-low
- s_tvalid, s_tready  in/out  1  upstream handshake
- s_tdata  in  8*byte_width  upstream data
- s_tstrb, s_tkeep  in  byte_width  upstream byte qualifiers
- s_tlast  in  1  upstream packet end
- s_tid / s_tdest / s_tuser  in  id_width / dest_width / user_width  upstream sideband
- m_tvalid  out  1  downstream valid
- m_tready  in  1  downstream ready
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  same widths as s_*  downstream payload
- byte_count  out  count_width  bytes delivered downstream (TKEEP-qualified)
- packet_count  out  count_width  packets delivered downstream (TLAST beats)

Behaviour:
- Storage: output register (OUT) driving m_*, plus a skid register (SKID). All outputs are registered; there is no combinational path from any s_* input to any m_* output, or from m_tready to s_tready.
- Reset: resetn low asynchronously clears m_tvalid=0, s_tready=0, byte_count=0, packet_count=0, and both valid flags. Payload registers are don't-care. On the first clk edge with resetn high, s_tready goes 1. m_tvalid stays 0 until a beat is accepted after reset. Reset asserted mid-packet discards both stored beats; no partial beat is emitted afterward.
- Transfer in: s_tvalid && s_tready. Transfer out: m_tvalid && m_tready.
- States:
  - EMPTY: m_tvalid=0, s_tready=1.
  - ONE: m_tvalid=1, s_tready=1.
  - FULL: m_tvalid=1, s_tready=0.
- Transitions:
  - EMPTY + in -> ONE; s_* loads OUT.
  - ONE + in + out -> ONE; OUT reloads from s_*.
  - ONE + in, no out -> FULL; s_* loads SKID, OUT held.
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE; SKID moves to OUT. No input is accepted because s_tready=0.
  - Otherwise the state holds.
- s_tready is a register, equal to the inverse of the next-state FULL flag (1 out of reset).
- Latency: a beat accepted at edge N appears on m_* after edge N. Sustained throughput is 1 beat/clk when m_tready=1.
- AXI rules at m_*:
  - Once m_tvalid rises, it and all m_* payload stay stable until the out transfer.
  - m_tvalid never depends on m_tready.
  - Beat order and all payload bits are preserved exactly. Nothing is dropped or duplicated.
- Counters (update on the edge of an out transfer):
  - byte_count += popcount(m_tkeep).
  - packet_count += 1 if m_tlast.
  - Both wrap modulo 2^count_width.
  - Position bytes (TKEEP=1, TSTRB=0) are counted; null bytes (TKEEP=0) are not.
- Upstream protocol violations (s_tvalid dropped without a transfer, payload changed while stalled) are not detected. Beats are forwarded as captured.

Test Plan:
- Reset and release: hold resetn=0 for 3 clk with s_tvalid=1 -> s_tready=0, m_tvalid=0, counts 0. One edge after release -> s_tready=1. First beat appears one clk after acceptance.
- Streaming: 8 beats with tdata=0..7, tkeep=4'hF, tlast on beat 7, m_tready=1 -> one beat/clk output, data 0..7 in order, byte_count=32, packet_count=1.
- Backpressure: stream continuously while m_tready=0 for 5 clk -> exactly 2 beats held, s_tready=0 after the 2nd acceptance, m_* stable throughout. On release, all beats are delivered in order with no gaps.
- Random ready/valid: 1000 random beats against a random m_tready -> scoreboard exact match, and the slave property set passes at m_*.
- Counting: beats with tkeep=4'b0011/tstrb=4'b0001, then 4'b0000, then 4'b1111 with tlast -> byte_count=6, packet_count=1. Preset near 2^count_width-1 with count_width=4 -> counts wrap to low values.
- Mid-packet reset: assert resetn=0 asynchronously (between edges) while in FULL -> m_tvalid=0 immediately. After release, only newly accepted beats appear and counts restart from 0.
